// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
//
// Owns the program counter and issues in-order requests to instruction memory
// over a valid/ready handshake. Returned words are buffered with their PCs in a
// first-word-fall-through FIFO that feeds decode. A redirect reloads the PC,
// flushes the buffer and marks every outstanding response for discard.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   DEPTH     buffer entries (2, 4 or 8); >= 3 sustains one instruction/cycle
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   Redirect, Redirect_PC new fetch target (bits [1:0] ignored)
//   Imem_Req_*            request channel (valid/ready, address = PC)
//   Imem_Resp_*           in-order response channel, never back-pressured
//   Instr_Valid/Ready     buffer head handshake towards decode
//   Instr, Instr_PC       head instruction word and its PC (0 when empty)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        Imem_Req_Valid,
    input  logic        Imem_Req_Ready,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Resp_Valid,
    input  logic [31:0] Imem_Resp_Data,
    output logic        Instr_Valid,
    input  logic        Instr_Ready,
    output logic [31:0] Instr,
    output logic [31:0] Instr_PC
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW+1:0] DepthW = DEPTH[CW+1:0];
    localparam logic [CW-1:0] DepthC = DEPTH[CW-1:0];

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic [CW+1:0] credit_used;
    logic          req_fire;
    logic          do_pop;
    logic          resp_drop;
    logic          resp_keep;
    logic          push;

    // Every slot that is buffered, in flight or owed a discard holds one credit.
    assign credit_used = {2'b00, count_q} + {2'b00, inflight_q} + {2'b00, drop_q};

    assign Imem_Req_Valid = rst & ~Redirect & (credit_used < DepthW);
    assign Imem_Addr      = pc_q;
    assign Instr_Valid    = (count_q != '0);
    assign Instr          = Instr_Valid ? data_mem_q[rd_ptr_q] : 32'h0;
    assign Instr_PC       = Instr_Valid ? pc_mem_q[rd_ptr_q] : 32'h0;

    assign req_fire  = Imem_Req_Valid & Imem_Req_Ready;
    assign do_pop    = Instr_Valid & Instr_Ready;
    assign resp_drop = Imem_Resp_Valid & (drop_q != '0);
    assign resp_keep = Imem_Resp_Valid & (drop_q == '0);

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        push       = 1'b0;

        if (Redirect) begin
            pc_d       = {Redirect_PC[31:2], 2'b00};
            resp_pc_d  = {Redirect_PC[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = '0;
            // Everything still outstanding after this edge must be discarded; a
            // response landing this cycle is thrown away and retires its slot.
            drop_d     = drop_q + inflight_q - CW'(Imem_Resp_Valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (resp_keep) begin
                push      = 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_keep);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= Imem_Resp_Data;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

`ifndef SYNTHESIS
    // The credit rule guarantees room for every kept response.
    property p_no_overflow;
        @(posedge clk) disable iff (!rst)
            !(!Redirect && resp_keep && (count_q == DepthC) && !do_pop);
    endproperty
    a_no_overflow : assert property (p_no_overflow)
        else $error("fetch_stage: response pushed into full buffer");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a fixed-latency memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        w_req_valid;
    logic [31:0] w_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned edge_cnt = 0;
    int unsigned lat      = 1;
    int unsigned r_edge;

    typedef struct { logic [31:0] addr; int unsigned edge_n; } req_t;
    typedef struct { int unsigned due; logic [31:0] addr; } pend_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; int unsigned edge_n; } pop_t;

    req_t  req_log[$];
    pend_t pend[$];
    pop_t  pop_log[$];

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .Redirect        (redirect),
        .Redirect_PC     (redirect_pc),
        .Imem_Req_Valid  (imem_req_valid),
        .Imem_Req_Ready  (imem_req_ready),
        .Imem_Addr       (imem_addr),
        .Imem_Resp_Valid (imem_resp_valid),
        .Imem_Resp_Data  (imem_resp_data),
        .Instr_Valid     (instr_valid),
        .Instr_Ready     (instr_ready),
        .Instr           (instr),
        .Instr_PC        (instr_pc)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (4)
    ) u_dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .Redirect        (1'b0),
        .Redirect_PC     (32'h0),
        .Imem_Req_Valid  (w_req_valid),
        .Imem_Req_Ready  (1'b1),
        .Imem_Addr       (w_addr),
        .Imem_Resp_Valid (1'b0),
        .Imem_Resp_Data  (32'h0),
        .Instr_Valid     (w_instr_valid),
        .Instr_Ready     (1'b0),
        .Instr           (w_instr),
        .Instr_PC        (w_instr_pc)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'hFFA0_0113;
            32'h8:   return 32'h0000_0193;
            default: return a ^ 32'h1357_9BDF;
        endcase
    endfunction

    function automatic logic [31:0] req_addr(input int i);
        if (i < req_log.size()) return req_log[i].addr;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] req_edge(input int i);
        if (i < req_log.size()) return req_log[i].edge_n;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pop_pc(input int i);
        if (i < pop_log.size()) return pop_log[i].pc;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_data(input int i);
        if (i < pop_log.size()) return pop_log[i].data;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_edge(input int i);
        if (i < pop_log.size()) return pop_log[i].edge_n;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Memory model and observers; edge_cnt here names the upcoming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            if (pend.size() != 0 && pend[0].due == edge_cnt) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = imem_word(pend[0].addr);
                void'(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{due: edge_cnt + lat, addr: imem_addr});
                req_log.push_back('{addr: imem_addr, edge_n: edge_cnt});
            end
            if (instr_valid && instr_ready && !redirect) begin
                pop_log.push_back('{data: instr, pc: instr_pc, edge_n: edge_cnt});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for three edges, check reset outputs, release just after an edge.
    task automatic do_reset();
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check_eq("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        #1;
        req_log.delete();
        pop_log.delete();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        instr_ready     = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Reset, address sequence, streaming and wrap-around.
        lat = 1;
        do_reset();
        @(negedge clk);
        check_eq("wrap_valid", {31'h0, w_req_valid}, 32'h1);
        check_eq("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check_eq("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check_eq("wrap_addr2", w_addr, 32'h0000_0000);
        repeat (6) step();
        check_eq("seq_addr0", req_addr(0), 32'h0);
        check_eq("seq_addr1", req_addr(1), 32'h4);
        check_eq("seq_addr2", req_addr(2), 32'h8);
        check_eq("seq_consec1", req_edge(1) - req_edge(0), 32'd1);
        check_eq("seq_consec2", req_edge(2) - req_edge(0), 32'd2);
        check_eq("str_data0", pop_data(0), 32'h0050_0093);
        check_eq("str_pc0", pop_pc(0), 32'h0);
        check_eq("str_data1", pop_data(1), 32'hFFA0_0113);
        check_eq("str_pc1", pop_pc(1), 32'h4);
        check_eq("str_data2", pop_data(2), 32'h0000_0193);
        check_eq("str_pc2", pop_pc(2), 32'h8);
        check_eq("str_first_lat", pop_edge(0) - req_edge(0), 32'd2);
        check_eq("str_consec", pop_edge(2) - pop_edge(0), 32'd2);

        // Backpressure: four credits, then stall until decode drains.
        lat = 1;
        do_reset();
        instr_ready = 1'b0;
        repeat (10) step();
        check_eq("bp_req_count", req_log.size(), 32'd4);
        check_eq("bp_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check_eq("bp_no_pop", pop_log.size(), 32'd0);
        instr_ready = 1'b1;
        repeat (12) step();
        check_eq("bp_pc0", pop_pc(0), 32'h0);
        check_eq("bp_pc1", pop_pc(1), 32'h4);
        check_eq("bp_pc2", pop_pc(2), 32'h8);
        check_eq("bp_pc3", pop_pc(3), 32'hC);
        check_eq("bp_data3", pop_data(3), imem_word(32'hC));
        check_eq("bp_resume", req_addr(4), 32'h10);

        // Redirect with two responses in flight (latency 3).
        lat = 3;
        do_reset();
        step();
        step();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0100;
        r_edge         = edge_cnt;
        step();
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        repeat (12) step();
        check_eq("rd_req_addr", req_addr(2), 32'h100);
        check_eq("rd_req_edge", req_edge(2), r_edge + 1);
        check_eq("rd_pc0", pop_pc(0), 32'h100);
        check_eq("rd_data0", pop_data(0), imem_word(32'h100));
        check_eq("rd_pc1", pop_pc(1), 32'h104);

        // Misaligned redirect coinciding with a live response and a pending pop.
        lat = 1;
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        r_edge      = edge_cnt;
        step();
        redirect    = 1'b0;
        @(negedge clk);
        check_eq("mis_addr", imem_addr, 32'h100);
        check_eq("mis_req_valid", {31'h0, imem_req_valid}, 32'h1);
        repeat (8) step();
        check_eq("mis_pc0", pop_pc(0), 32'h100);
        check_eq("mis_data0", pop_data(0), imem_word(32'h100));
        check_eq("mis_lat", pop_edge(0), r_edge + 3);
        check_eq("mis_pc1", pop_pc(1), 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
